// File: rtl/genesis_pad_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// genesis_pad_conditioner : pad-type qualification, button masking, debounce,
// A/B/C turbo and per-frame latching of the Genesis joystick vector. Rev 1.0
// ---------------------------------------------------------------------------
module genesis_pad_conditioner #(
  parameter int TICK_DIV        = 50000,
  parameter int DEB_TICKS       = 4,
  parameter int TYPE_QUAL_TICKS = 64,
  parameter int TURBO_FRAMES    = 4,
  parameter bit LATCH_ON_VBLANK = 1'b1
) (
  input  logic        iCLK,
  input  logic        iN_RESET,
  input  logic [11:0] iGENPAD_DECODED,
  input  logic [1:0]  iGENPAD_TYPE,
  input  logic        iVBLANK,
  input  logic [2:0]  iTURBO_EN,
  output logic [11:0] oJOY,
  output logic        oFRAME_STROBE,
  output logic [1:0]  oPAD_TYPE,
  output logic        oPAD_VALID,
  output logic        oPAD_ERROR
);

  localparam int                   c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);
  localparam logic [7:0]           c_qual      = 8'(TYPE_QUAL_TICKS);
  localparam logic [3:0]           c_deb       = 4'(DEB_TICKS);
  localparam logic [3:0]           c_tmax      = 4'(TURBO_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  logic [c_presc_w-1:0] r_presc;
  logic                 w_tick;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_cand_type;
  logic [1:0]           w_cand_nxt;
  logic [7:0]           r_qcnt;
  logic [7:0]           w_qcnt_nxt;
  logic                 w_requal;
  logic                 w_active;
  logic                 w_exit;
  logic [11:0]          w_mask;
  logic [11:0]          w_sample;
  logic [11:0]          r_cand_vec;
  logic [11:0]          r_stable_vec;
  logic [11:0]          w_turbo;
  logic [3:0]           r_dcnt;
  logic [3:0]           r_tcnt;
  logic                 r_vb_meta;
  logic                 r_vb_sync;
  logic                 r_vb_prev;
  logic                 r_vb_rise;
  logic                 w_twrap;
  logic [2:0]           r_phase;

  assign w_tick = (r_presc == c_presc_max);

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET)   r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Any restart or QUALIFY step re-evaluates the decision, so a qualify
  // length of one resolves on the very tick of the change.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand_type;
    w_qcnt_nxt  = r_qcnt;
    w_requal    = 1'b0;
    if (w_tick) begin
      if (r_state == ST_INIT || iGENPAD_TYPE != r_cand_type) begin
        w_cand_nxt = iGENPAD_TYPE;
        w_qcnt_nxt = 8'd1;
        w_requal   = 1'b1;
      end else if (r_state == ST_QUALIFY) begin
        w_qcnt_nxt = r_qcnt + 8'd1;
        w_requal   = 1'b1;
      end
      if (w_requal) begin
        if (w_qcnt_nxt == c_qual) w_state_nxt = (w_cand_nxt == 2'd3) ? ST_ERROR : ST_ACTIVE;
        else                      w_state_nxt = ST_QUALIFY;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      r_state     <= ST_INIT;
      r_cand_type <= 2'd0;
      r_qcnt      <= 8'd0;
      oPAD_VALID  <= 1'b0;
      oPAD_ERROR  <= 1'b0;
      oPAD_TYPE   <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand_type <= w_cand_nxt;
      r_qcnt      <= w_qcnt_nxt;
      oPAD_VALID  <= (w_state_nxt == ST_ACTIVE);
      oPAD_ERROR  <= (w_state_nxt == ST_ERROR);
      oPAD_TYPE   <= (w_state_nxt == ST_ACTIVE) ? w_cand_nxt : 2'd0;
    end
  end

  assign w_active = (r_state == ST_ACTIVE);
  assign w_exit   = w_active && (w_state_nxt != ST_ACTIVE);

  always_comb begin
    case (r_cand_type)
      2'd0:    w_mask = 12'h06F;
      2'd1:    w_mask = 12'h0FF;
      default: w_mask = 12'hFFF;
    endcase
  end

  assign w_sample = iGENPAD_DECODED & w_mask;

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      r_cand_vec   <= 12'd0;
      r_stable_vec <= 12'd0;
      r_dcnt       <= 4'd0;
    end else if (!w_active) begin
      r_cand_vec   <= 12'd0;
      r_stable_vec <= 12'd0;
      r_dcnt       <= 4'd0;
    end else if (w_tick) begin
      if (w_sample != r_cand_vec) begin
        r_cand_vec <= w_sample;
        r_dcnt     <= 4'd1;
        if (c_deb == 4'd1) r_stable_vec <= w_sample;
      end else if (r_dcnt < c_deb) begin
        r_dcnt <= r_dcnt + 4'd1;
        if (r_dcnt + 4'd1 == c_deb) r_stable_vec <= r_cand_vec;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      r_vb_meta <= 1'b0;
      r_vb_sync <= 1'b0;
      r_vb_prev <= 1'b0;
      r_vb_rise <= 1'b0;
    end else begin
      r_vb_meta <= iVBLANK;
      r_vb_sync <= r_vb_meta;
      r_vb_prev <= r_vb_sync;
      r_vb_rise <= r_vb_sync & ~r_vb_prev;
    end
  end

  assign w_twrap = r_vb_rise && (r_tcnt == c_tmax);

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET)      r_tcnt <= 4'd0;
    else if (r_vb_rise) r_tcnt <= (r_tcnt == c_tmax) ? 4'd0 : r_tcnt + 4'd1;
  end

  // Released bits park their phase at 1 so a fresh press is seen at once.
  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET)      r_phase <= 3'd0;
    else if (!w_active) r_phase <= 3'd0;
    else                r_phase <= ~r_stable_vec[6:4] | (r_phase ^ ({3{w_twrap}} & iTURBO_EN));
  end

  always_comb begin
    w_turbo      = r_stable_vec;
    w_turbo[6:4] = r_stable_vec[6:4] & (r_phase | ~iTURBO_EN);
  end

  generate
    if (LATCH_ON_VBLANK) begin : g_latch
      always_ff @(posedge iCLK or negedge iN_RESET) begin
        if (!iN_RESET) begin
          oJOY          <= 12'd0;
          oFRAME_STROBE <= 1'b0;
        end else if (!w_active || w_exit) begin
          oJOY          <= 12'd0;
          oFRAME_STROBE <= 1'b0;
        end else begin
          if (r_vb_rise) oJOY <= w_turbo;
          oFRAME_STROBE <= r_vb_rise;
        end
      end
    end else begin : g_follow
      always_ff @(posedge iCLK or negedge iN_RESET) begin
        if (!iN_RESET) begin
          oJOY          <= 12'd0;
          oFRAME_STROBE <= 1'b0;
        end else if (!w_active || w_exit) begin
          oJOY          <= 12'd0;
          oFRAME_STROBE <= 1'b0;
        end else begin
          oJOY          <= w_turbo;
          oFRAME_STROBE <= r_vb_rise;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
